// File: rtl/bcd_time_of_day.sv
// -----------------------------------------------------------------------------
// bcd_time_of_day
//
// Time-of-day counter in packed BCD (hh:mm:ss). The 1 Hz divider output arrives
// on tick_in as an asynchronous level. It is synchronised, edge-detected and
// used as a count enable. It is never used as a clock. Everything runs on clk.
//
// Build option:
//   CLOCK_12H_EN  defined   -> 12 h mode: hh 01..12 plus the pm flag.
//                 undefined -> 24 h mode: hh 00..23, pm tied to 0, load_pm ignored.
//   The port list is the same in both builds.
//
// Parameters:
//   SYNC_STAGES  synchroniser depth for tick_in (legal range 2..4)
//
// Ports:
//   clk        system clock, rising edge
//   reset      asynchronous active-low reset; release is synchronous to clk
//   tick_in    1 Hz square wave, asynchronous to clk
//   run        1 = count on each tick, 0 = hold (ticks are discarded)
//   load       1-cycle strobe; takes load_hh/mm/ss (and load_pm) when valid
//   load_hh    BCD hours   {tens, units}
//   load_mm    BCD minutes {tens, units}
//   load_ss    BCD seconds {tens, units}
//   load_pm    PM flag for a load (12 h mode only)
//   hh, mm, ss current time, packed BCD
//   pm         PM indicator (constant 0 in 24 h mode)
//   sec_pulse  1-cycle pulse in the cycle each counted second appears on ss
//   min_pulse  1-cycle pulse when ss wraps 59 -> 00
//   day_pulse  1-cycle pulse when the time wraps to the start of the day
//   load_err   1-cycle pulse when a load was rejected as invalid
//
// Latency: a tick_in rise that is first sampled at edge N updates ss at edge
// N + SYNC_STAGES + 1. All outputs come straight from flops.
// -----------------------------------------------------------------------------
module bcd_time_of_day #(
  parameter int SYNC_STAGES = 2
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       tick_in,
  input  logic       run,
  input  logic       load,
  input  logic [7:0] load_hh,
  input  logic [7:0] load_mm,
  input  logic [7:0] load_ss,
  input  logic       load_pm,
  output logic [7:0] hh,
  output logic [7:0] mm,
  output logic [7:0] ss,
  output logic       pm,
  output logic       sec_pulse,
  output logic       min_pulse,
  output logic       day_pulse,
  output logic       load_err
);

`ifdef CLOCK_12H_EN
  localparam logic [7:0] HH_RESET = 8'h12;
  localparam logic [7:0] HH_MAX   = 8'h12;
`else
  localparam logic [7:0] HH_RESET = 8'h00;
  localparam logic [7:0] HH_MAX   = 8'h23;
`endif

  // Edges seen during the first SYNC_STAGES+1 cycles after reset release are
  // ignored, so a tick_in that is already high at release is never counted.
  localparam logic [2:0] GUARD_CYCLES = 3'(SYNC_STAGES + 1);

  // ---------------------------------------------------------------------------
  // BCD helpers
  // ---------------------------------------------------------------------------

  // Increments one packed two-digit BCD value. The caller handles the wrap
  // at the top of the range, so the tens digit never exceeds 9 here.
  function automatic logic [7:0] bcd_inc(input logic [7:0] v);
    if (v[3:0] == 4'd9) bcd_inc = {v[7:4] + 4'd1, 4'd0};
    else                bcd_inc = {v[7:4], v[3:0] + 4'd1};
  endfunction

  // True when both nibbles are decimal digits and the value is <= limit.
  // Once both nibbles are legal digits, a plain compare of the packed values
  // orders them the same way the decimal numbers are ordered.
  function automatic logic bcd_in_range(input logic [7:0] v, input logic [7:0] limit);
    bcd_in_range = (v[7:4] <= 4'd9) && (v[3:0] <= 4'd9) && (v <= limit);
  endfunction

  // ---------------------------------------------------------------------------
  // tick_in synchroniser, edge detector and post-reset guard
  // ---------------------------------------------------------------------------
  logic [SYNC_STAGES-1:0] sync_q;
  logic                   hist_q;
  logic                   tick_q;
  logic [2:0]             guard_q;
  logic                   tick_rise;
  logic                   guard_done;

  assign tick_rise  = sync_q[SYNC_STAGES-1] & ~hist_q;
  assign guard_done = (guard_q == GUARD_CYCLES);

  // NOTE: state is updated with non-blocking assignments only, so every flop
  // in this block samples the values from before the edge. This is what
  // makes sync_q behave as a shift chain and not as a single wire.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sync_q  <= '0;
      hist_q  <= 1'b0;
      tick_q  <= 1'b0;
      guard_q <= '0;
    end else begin
      sync_q  <= {sync_q[SYNC_STAGES-2:0], tick_in};
      hist_q  <= sync_q[SYNC_STAGES-1];
      // One flop between the edge detector and the counter. It gives the
      // fixed SYNC_STAGES+1 latency and keeps the detector out of the carry path.
      tick_q  <= tick_rise & guard_done;
      if (!guard_done) guard_q <= guard_q + 3'd1;
    end
  end

  // ---------------------------------------------------------------------------
  // Next-time values and load validation
  // ---------------------------------------------------------------------------
  logic       ss_wrap;
  logic       mm_wrap;
  logic       day_wrap;
  logic [7:0] ss_next;
  logic [7:0] mm_next;
  logic [7:0] hh_next;
  logic       load_valid;
`ifdef CLOCK_12H_EN
  logic       pm_next;
`endif

  // NOTE: every signal written here gets a default value first, so no
  // branch can leave a value unassigned. An unassigned value would infer a latch.
  always_comb begin
    ss_wrap  = (ss == 8'h59);
    mm_wrap  = (mm == 8'h59);
    ss_next  = ss_wrap ? 8'h00 : bcd_inc(ss);
    mm_next  = mm_wrap ? 8'h00 : bcd_inc(mm);
    hh_next  = bcd_inc(hh);
    day_wrap = 1'b0;
`ifdef CLOCK_12H_EN
    pm_next  = pm;
    if (hh == 8'h12) begin
      hh_next = 8'h01;               // 12:59:59 -> 01:00:00, pm unchanged
    end else if (hh == 8'h11) begin
      hh_next  = 8'h12;              // 11:59:59 -> 12:00:00, pm toggles
      pm_next  = ~pm;
      day_wrap = pm;                 // 11:59:59 PM -> 12:00:00 AM starts a new day
    end
`else
    if (hh == 8'h23) begin
      hh_next  = 8'h00;
      day_wrap = 1'b1;
    end
`endif
  end

  always_comb begin
    load_valid = bcd_in_range(load_hh, HH_MAX) &&
                 bcd_in_range(load_mm, 8'h59)  &&
                 bcd_in_range(load_ss, 8'h59);
`ifdef CLOCK_12H_EN
    // Hour 00 does not exist on a 12 h dial.
    load_valid = load_valid && (load_hh != 8'h00);
`endif
  end

  // ---------------------------------------------------------------------------
  // Time registers and pulse outputs
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      hh        <= HH_RESET;
      mm        <= 8'h00;
      ss        <= 8'h00;
      sec_pulse <= 1'b0;
      min_pulse <= 1'b0;
      day_pulse <= 1'b0;
      load_err  <= 1'b0;
`ifdef CLOCK_12H_EN
      pm        <= 1'b0;
`endif
    end else begin
      sec_pulse <= 1'b0;
      min_pulse <= 1'b0;
      day_pulse <= 1'b0;
      load_err  <= 1'b0;
      if (load) begin
        // A load takes priority. A tick in the same cycle is dropped on
        // purpose, whether or not the load is accepted.
        if (load_valid) begin
          hh <= load_hh;
          mm <= load_mm;
          ss <= load_ss;
`ifdef CLOCK_12H_EN
          pm <= load_pm;
`endif
        end else begin
          load_err <= 1'b1;
        end
      end else if (tick_q && run) begin
        sec_pulse <= 1'b1;
        ss        <= ss_next;
        if (ss_wrap) begin
          min_pulse <= 1'b1;
          mm        <= mm_next;
          if (mm_wrap) begin
            hh        <= hh_next;
            day_pulse <= day_wrap;
`ifdef CLOCK_12H_EN
            pm        <= pm_next;
`endif
          end
        end
      end
    end
  end

`ifndef CLOCK_12H_EN
  // 24 h mode has no AM/PM. load_pm stays in the port list so that both
  // builds have the same interface.
  logic unused_load_pm;
  assign pm             = 1'b0;
  assign unused_load_pm = load_pm;
`endif

endmodule

// File: tb/tb_bcd_time_of_day.sv
// -----------------------------------------------------------------------------
// tb_bcd_time_of_day
//
// Self-checking bench for bcd_time_of_day. The reference model holds the time
// as a single integer: seconds since midnight, 0..86399. Displayed hh/mm/ss/pm,
// pulse expectations and load validity all come from that integer with plain
// arithmetic. Inputs are driven on the falling edge. Outputs are sampled on
// the falling edge.
// -----------------------------------------------------------------------------
module tb_bcd_time_of_day;

  localparam int S   = 2;
  localparam int DAY = 86400;

  logic       clk = 1'b0;
  logic       reset;
  logic       tick_in;
  logic       run;
  logic       load;
  logic [7:0] load_hh;
  logic [7:0] load_mm;
  logic [7:0] load_ss;
  logic       load_pm;
  logic [7:0] hh;
  logic [7:0] mm;
  logic [7:0] ss;
  logic       pm;
  logic       sec_pulse;
  logic       min_pulse;
  logic       day_pulse;
  logic       load_err;

  int n_checks = 0;
  int n_fail   = 0;
  int model_t  = 0;   // reference time, seconds since midnight

  always #5 clk = ~clk;

  bcd_time_of_day #(.SYNC_STAGES(S)) dut (
    .clk       (clk),
    .reset     (reset),
    .tick_in   (tick_in),
    .run       (run),
    .load      (load),
    .load_hh   (load_hh),
    .load_mm   (load_mm),
    .load_ss   (load_ss),
    .load_pm   (load_pm),
    .hh        (hh),
    .mm        (mm),
    .ss        (ss),
    .pm        (pm),
    .sec_pulse (sec_pulse),
    .min_pulse (min_pulse),
    .day_pulse (day_pulse),
    .load_err  (load_err)
  );

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation exceeded its time limit");
    $fatal(1, "watchdog expired");
  end

  // ---------------------------------------------------------------------------
  // Reference model
  // ---------------------------------------------------------------------------
  function automatic logic [7:0] to_bcd(input int v);
    return {4'(v / 10), 4'(v % 10)};
  endfunction

  // Expected {hh, mm, ss, pm} for a time given in seconds since midnight.
  function automatic logic [24:0] disp(input int t);
    int   h24;
    int   h;
    logic p;
    h24 = t / 3600;
    h   = h24;
    p   = 1'b0;
`ifdef CLOCK_12H_EN
    p = (h24 >= 12);
    h = h24 % 12;
    if (h == 0) h = 12;
`endif
    return {to_bcd(h), to_bcd((t / 60) % 60), to_bcd(t % 60), p};
  endfunction

  // Checks the fields currently on the load inputs. Returns 1 if the load is
  // valid, and gives the loaded time in seconds since midnight.
  function automatic bit decode_load(output int t);
    int h;
    int m;
    int s;
    bit ok;
    ok = (load_hh[7:4] <= 4'd9) && (load_hh[3:0] <= 4'd9) &&
         (load_mm[7:4] <= 4'd9) && (load_mm[3:0] <= 4'd9) &&
         (load_ss[7:4] <= 4'd9) && (load_ss[3:0] <= 4'd9);
    h  = int'(load_hh[7:4]) * 10 + int'(load_hh[3:0]);
    m  = int'(load_mm[7:4]) * 10 + int'(load_mm[3:0]);
    s  = int'(load_ss[7:4]) * 10 + int'(load_ss[3:0]);
    ok = ok && (m <= 59) && (s <= 59);
`ifdef CLOCK_12H_EN
    ok = ok && (h >= 1) && (h <= 12);
    h  = (h % 12) + (load_pm ? 12 : 0);
`else
    ok = ok && (h <= 23);
`endif
    t = h * 3600 + m * 60 + s;
    return ok;
  endfunction

  // Advances the model by one tick, honouring run. Gives the expected
  // number of sec, min and day pulses.
  task automatic model_tick(output int e_sec, output int e_min, output int e_day);
    e_sec = 0;
    e_min = 0;
    e_day = 0;
    if (run) begin
      e_sec   = 1;
      e_min   = (model_t % 60 == 59) ? 1 : 0;
      e_day   = (model_t == DAY - 1) ? 1 : 0;
      model_t = (model_t + 1) % DAY;
    end
  endtask

  // ---------------------------------------------------------------------------
  // Stimulus helpers (they compare nothing themselves)
  // ---------------------------------------------------------------------------
  task automatic do_load(input logic [7:0] h, input logic [7:0] m, input logic [7:0] s,
                         input logic p, output logic err, output logic exp_err);
    int tn;
    bit ok;
    @(negedge clk);
    load_hh = h;
    load_mm = m;
    load_ss = s;
    load_pm = p;
    load    = 1'b1;
    ok      = decode_load(tn);
    @(negedge clk);
    err     = load_err;
    load    = 1'b0;
    exp_err = !ok;
    if (ok) model_t = tn;
  endtask

  // Produces one tick_in rise and counts the pulses over the whole window.
  task automatic apply_tick(output int n_sec, output int n_min, output int n_day);
    n_sec = 0;
    n_min = 0;
    n_day = 0;
    @(negedge clk);
    tick_in = 1'b1;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      if (k == 3) tick_in = 1'b0;
      n_sec += int'(sec_pulse);
      n_min += int'(min_pulse);
      n_day += int'(day_pulse);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Tests
  // ---------------------------------------------------------------------------
  task automatic test_reset();
    reset   = 1'b0;
    tick_in = 1'b1;
    run     = 1'b1;
    load    = 1'b0;
    load_hh = 8'h00;
    load_mm = 8'h00;
    load_ss = 8'h00;
    load_pm = 1'b0;
    model_t = 0;
    repeat (3) @(negedge clk);
    n_checks++;
    if ({hh, mm, ss, pm} !== disp(0)) begin
      n_fail++;
      $display("FAIL reset_time: got %h expected %h", {hh, mm, ss, pm}, disp(0));
    end
    n_checks++;
    if ({sec_pulse, min_pulse, day_pulse, load_err} !== 4'b0000) begin
      n_fail++;
      $display("FAIL reset_pulses: got %b expected 0000",
               {sec_pulse, min_pulse, day_pulse, load_err});
    end
    reset = 1'b1;   // released with tick_in already high
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      n_checks++;
      if ({sec_pulse, ss} !== 9'h000) begin
        n_fail++;
        $display("FAIL release_high_tick cycle %0d: sec_pulse=%b ss=%h expected 0 and 00",
                 k, sec_pulse, ss);
      end
    end
    tick_in = 1'b0;
    repeat (4) @(negedge clk);
  endtask

  task automatic test_latency();
    int t0;
    t0 = model_t;
    @(negedge clk);
    tick_in = 1'b1;   // first sampled at the next rising edge, edge N
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);  // just after edge N+k
      n_checks++;
      if ({hh, mm, ss, pm} !== disp((k >= S + 1) ? t0 + 1 : t0)) begin
        n_fail++;
        $display("FAIL latency_time N+%0d: got %h expected %h", k, {hh, mm, ss, pm},
                 disp((k >= S + 1) ? t0 + 1 : t0));
      end
      n_checks++;
      if (sec_pulse !== (k == S + 1)) begin
        n_fail++;
        $display("FAIL latency_sec_pulse N+%0d: got %b expected %b", k, sec_pulse, k == S + 1);
      end
      if (k == 3) tick_in = 1'b0;
    end
    model_t = t0 + 1;
    repeat (4) @(negedge clk);
  endtask

  task automatic test_rollover();
    logic [24:0] f;
    logic        err;
    logic        exp_err;
    int          n_sec, n_min, n_day, e_sec, e_min, e_day;
    f = disp(DAY - 2);   // 23:59:58, or 11:59:58 PM on a 12 h dial
    do_load(f[24:17], f[16:9], f[8:1], f[0], err, exp_err);
    n_checks++;
    if (err !== exp_err) begin
      n_fail++;
      $display("FAIL rollover_load_err: got %b expected %b", err, exp_err);
    end
    for (int i = 0; i < 2; i++) begin
      apply_tick(n_sec, n_min, n_day);
      model_tick(e_sec, e_min, e_day);
      n_checks++;
      if ({hh, mm, ss, pm} !== disp(model_t)) begin
        n_fail++;
        $display("FAIL rollover_time tick %0d: got %h expected %h", i, {hh, mm, ss, pm},
                 disp(model_t));
      end
      n_checks++;
      if (n_sec != e_sec || n_min != e_min || n_day != e_day) begin
        n_fail++;
        $display("FAIL rollover_pulses tick %0d: got sec/min/day %0d/%0d/%0d expected %0d/%0d/%0d",
                 i, n_sec, n_min, n_day, e_sec, e_min, e_day);
      end
    end
  endtask

  task automatic test_load_err();
    logic       err;
    logic       exp_err;
    logic [7:0] bad_h [2];
    logic [7:0] bad_s [2];
    bad_h[0] = 8'h24; bad_s[0] = 8'h00;
    bad_h[1] = 8'h10; bad_s[1] = 8'h5A;
    for (int i = 0; i < 2; i++) begin
      do_load(bad_h[i], 8'h00, bad_s[i], 1'b0, err, exp_err);
      n_checks++;
      if (err !== 1'b1 || exp_err !== 1'b1) begin
        n_fail++;
        $display("FAIL load_err_pulse %0d: got %b model %b expected 1", i, err, exp_err);
      end
      n_checks++;
      if ({hh, mm, ss, pm} !== disp(model_t)) begin
        n_fail++;
        $display("FAIL load_err_time %0d: got %h expected %h", i, {hh, mm, ss, pm}, disp(model_t));
      end
      @(negedge clk);
      n_checks++;
      if (load_err !== 1'b0) begin
        n_fail++;
        $display("FAIL load_err_width %0d: got %b expected 0", i, load_err);
      end
    end
    do_load(8'h12, 8'h34, 8'h56, 1'b0, err, exp_err);
    n_checks++;
    if (err !== 1'b0 || {hh, mm, ss} !== 24'h123456) begin
      n_fail++;
      $display("FAIL load_valid: got err=%b time=%h expected 0 and 123456", err, {hh, mm, ss});
    end
  endtask

  task automatic test_collision();
    logic [24:0] f;
    logic        err;
    logic        exp_err;
    int          n_sec;
    f = disp(int'($urandom_range(0, DAY - 1)));
    @(negedge clk);
    tick_in = 1'b1;              // sampled at edge N; the count would be at N+3
    repeat (S) @(negedge clk);
    do_load(f[24:17], f[16:9], f[8:1], f[0], err, exp_err);   // load is high at N+3
    n_checks++;
    if (sec_pulse !== 1'b0) begin
      n_fail++;
      $display("FAIL collision_sec_pulse: got %b expected 0", sec_pulse);
    end
    tick_in = 1'b0;
    n_sec   = 0;
    repeat (6) begin
      @(negedge clk);
      n_sec += int'(sec_pulse);
    end
    n_checks++;
    if ({hh, mm, ss, pm} !== disp(model_t) || n_sec != 0 || err !== exp_err) begin
      n_fail++;
      $display("FAIL collision_time: got %h sec=%0d err=%b expected %h sec=0 err=%b",
               {hh, mm, ss, pm}, n_sec, err, disp(model_t), exp_err);
    end
  endtask

  task automatic test_hold();
    int n_sec, n_min, n_day, e_sec, e_min, e_day;
    run = 1'b0;
    for (int i = 0; i < 3; i++) begin
      apply_tick(n_sec, n_min, n_day);
      model_tick(e_sec, e_min, e_day);
      n_checks++;
      if ({hh, mm, ss, pm} !== disp(model_t) || n_sec != e_sec) begin
        n_fail++;
        $display("FAIL hold tick %0d: got %h sec=%0d expected %h sec=%0d", i,
                 {hh, mm, ss, pm}, n_sec, disp(model_t), e_sec);
      end
    end
    run = 1'b1;
  endtask

`ifdef CLOCK_12H_EN
  task automatic test_12h();
    logic        err;
    logic        exp_err;
    int          n_sec, n_min, n_day, e_sec, e_min, e_day;
    logic [24:0] want [2];
    logic [7:0]  ld_h [2];
    want[0] = {8'h12, 8'h00, 8'h00, 1'b1};
    want[1] = {8'h01, 8'h00, 8'h00, 1'b1};
    ld_h[0] = 8'h11;
    ld_h[1] = 8'h12;
    for (int i = 0; i < 2; i++) begin
      do_load(ld_h[i], 8'h59, 8'h59, i == 1, err, exp_err);
      apply_tick(n_sec, n_min, n_day);
      model_tick(e_sec, e_min, e_day);
      n_checks++;
      if ({hh, mm, ss, pm} !== want[i] || disp(model_t) !== want[i] || n_day != 0) begin
        n_fail++;
        $display("FAIL twelve_hour %0d: got %h day=%0d expected %h day=0", i,
                 {hh, mm, ss, pm}, n_day, want[i]);
      end
    end
  endtask
`endif

  task automatic test_random();
    logic [24:0] f;
    logic [7:0]  h, m, s;
    logic        p;
    logic        err;
    logic        exp_err;
    int          t_r;
    int          n_sec, n_min, n_day, e_sec, e_min, e_day;
    for (int i = 0; i < 150; i++) begin
      if ($urandom_range(0, 2) == 0) begin
        t_r = int'($urandom_range(0, DAY - 1));
        case ($urandom_range(0, 3))
          0:       t_r = DAY - 1 - int'($urandom_range(0, 1));
          1:       t_r = (t_r / 3600) * 3600 + 3599 - int'($urandom_range(0, 1));
          default: ;
        endcase
        f = disp(t_r);
        h = f[24:17];
        m = f[16:9];
        s = f[8:1];
        p = 1'($urandom_range(0, 1));
        case ($urandom_range(0, 5))
          0:       h = 8'($urandom_range(0, 255));
          1:       m = 8'($urandom_range(0, 255));
          2:       s = 8'($urandom_range(0, 255));
          default: ;
        endcase
        do_load(h, m, s, p, err, exp_err);
        n_checks++;
        if (err !== exp_err || {hh, mm, ss, pm} !== disp(model_t)) begin
          n_fail++;
          $display("FAIL random_load %0d: got err=%b time=%h expected err=%b time=%h", i,
                   err, {hh, mm, ss, pm}, exp_err, disp(model_t));
        end
      end else begin
        run = ($urandom_range(0, 3) != 0);
        apply_tick(n_sec, n_min, n_day);
        model_tick(e_sec, e_min, e_day);
        n_checks++;
        if ({hh, mm, ss, pm} !== disp(model_t) ||
            n_sec != e_sec || n_min != e_min || n_day != e_day) begin
          n_fail++;
          $display("FAIL random_tick %0d: got %h %0d/%0d/%0d expected %h %0d/%0d/%0d", i,
                   {hh, mm, ss, pm}, n_sec, n_min, n_day, disp(model_t), e_sec, e_min, e_day);
        end
      end
    end
    run = 1'b1;
  endtask

  task automatic test_reset_mid();
    int n_sec;
    @(negedge clk);
    tick_in = 1'b1;
    repeat (2) @(negedge clk);   // the edge is partway through the synchroniser
    #2 reset = 1'b0;
    #1;
    model_t = 0;
    n_checks++;
    if ({hh, mm, ss, pm} !== disp(0) ||
        {sec_pulse, min_pulse, day_pulse, load_err} !== 4'b0000) begin
      n_fail++;
      $display("FAIL reset_mid_clear: got %h pulses %b expected %h pulses 0000",
               {hh, mm, ss, pm}, {sec_pulse, min_pulse, day_pulse, load_err}, disp(0));
    end
    @(negedge clk);
    reset = 1'b1;
    n_sec = 0;
    repeat (10) begin
      @(negedge clk);
      n_sec += int'(sec_pulse);
    end
    n_checks++;
    if (n_sec != 0 || {hh, mm, ss, pm} !== disp(0)) begin
      n_fail++;
      $display("FAIL reset_mid_discard: got %h sec=%0d expected %h sec=0",
               {hh, mm, ss, pm}, n_sec, disp(0));
    end
    tick_in = 1'b0;
    repeat (4) @(negedge clk);
  endtask

  initial begin
    test_reset();
    test_latency();
    test_rollover();
    test_load_err();
    test_collision();
    test_hold();
`ifdef CLOCK_12H_EN
    test_12h();
`endif
    test_random();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
